// File: rtl/vregfile_write_scheduler.sv
// Write-port arbiter for the vector register file (ALU vs. load unit) plus a
// per-register busy scoreboard for RAW/WAW hazard stalls at issue.
module vregfile_write_scheduler #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_wr_valid,
    output logic                  alu_wr_ready,
    input  logic [ADDR_WIDTH-1:0] alu_wr_addr,
    input  logic [DATA_WIDTH-1:0] alu_wr_data,
    input  logic                  lsu_wr_valid,
    output logic                  lsu_wr_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_wr_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wr_data,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    output logic                  reserve_ready,
    input  logic [ADDR_WIDTH-1:0] check_addr_1,
    input  logic [ADDR_WIDTH-1:0] check_addr_2,
    output logic                  busy_1,
    output logic                  busy_2,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [NUM_REGS-1:0]   busy_bits
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready is a function of the valids and arbitration state only.

    logic                last_grant_lsu;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                alu_accept;
    logic                lsu_accept;

    // On a tie, grant whichever side did not win the previous accepted write.
    assign alu_wr_ready = !reset && alu_wr_valid && (!lsu_wr_valid || last_grant_lsu);
    assign lsu_wr_ready = !reset && lsu_wr_valid && (!alu_wr_valid || !last_grant_lsu);
    assign alu_accept   = alu_wr_valid && alu_wr_ready;
    assign lsu_accept   = lsu_wr_valid && lsu_wr_ready;

    assign reserve_ready = !busy_q[reserve_addr];
    assign busy_1        = busy_q[check_addr_1];
    assign busy_2        = busy_q[check_addr_2];
    assign busy_bits     = busy_q;

    // Clear is applied first so a reservation of the register being written wins.
    always_comb begin
        busy_next = busy_q;
        if (rf_write_enable) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (reserve_valid && reserve_ready) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q          <= '0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            last_grant_lsu  <= 1'b1;
        end else begin
            busy_q          <= busy_next;
            rf_write_enable <= alu_accept || lsu_accept;
            if (alu_accept) begin
                rf_write_addr  <= alu_wr_addr;
                rf_write_data  <= alu_wr_data;
                last_grant_lsu <= 1'b0;
            end else if (lsu_accept) begin
                rf_write_addr  <= lsu_wr_addr;
                rf_write_data  <= lsu_wr_data;
                last_grant_lsu <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vregfile_write_scheduler.sv
// Bench for vregfile_write_scheduler: directed vector table, then random traffic
// against a scoreboard-style reference model.
module tb_vregfile_write_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         alu_wr_valid, alu_wr_ready;
    logic [4:0]   alu_wr_addr;
    logic [127:0] alu_wr_data;
    logic         lsu_wr_valid, lsu_wr_ready;
    logic [4:0]   lsu_wr_addr;
    logic [127:0] lsu_wr_data;
    logic         reserve_valid, reserve_ready;
    logic [4:0]   reserve_addr, check_addr_1, check_addr_2;
    logic         busy_1, busy_2;
    logic         rf_write_enable;
    logic [4:0]   rf_write_addr;
    logic [127:0] rf_write_data;
    logic [31:0]  busy_bits;

    vregfile_write_scheduler #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(128)) dut (
        .clock(clock), .reset(reset),
        .alu_wr_valid(alu_wr_valid), .alu_wr_ready(alu_wr_ready),
        .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
        .lsu_wr_valid(lsu_wr_valid), .lsu_wr_ready(lsu_wr_ready),
        .lsu_wr_addr(lsu_wr_addr), .lsu_wr_data(lsu_wr_data),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .reserve_ready(reserve_ready),
        .check_addr_1(check_addr_1), .check_addr_2(check_addr_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy_bits(busy_bits)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic rst, av; logic [4:0] aa; logic [127:0] ad;
        logic lv; logic [4:0] la; logic [127:0] ld;
        logic rv; logic [4:0] ra, c1, c2;
        logic e_ar, e_lr, e_rr, e_b1, e_b2; logic [31:0] e_bb;
        logic e_we; logic [4:0] e_wa; logic [127:0] e_wd;
    } vec_t;

    localparam logic [127:0] D0 = 128'h0;
    localparam logic [127:0] D1 = 128'h1234_5678_9ABC_DEF0_1122_3344_5566_7788;
    localparam logic [127:0] D2 = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] D4 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_7654_3210;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: register busy flags, round-robin memory, and the queue
    // of accepted writes ({addr, data}) waiting to reach the register file.
    bit           m_busy[32];
    bit           m_last_lsu;
    logic [132:0] exp_q[$];
    logic [4:0]   m_hold_addr;
    logic [127:0] m_hold_data;

    function automatic vec_t mk(input logic rst, av, input logic [4:0] aa, input logic [127:0] ad,
                                input logic lv, input logic [4:0] la, input logic [127:0] ld,
                                input logic rv, input logic [4:0] ra, c1, c2,
                                input logic ar, lr, rr, b1, b2, input logic [31:0] bb,
                                input logic we, input logic [4:0] wa, input logic [127:0] wd);
        vec_t v;
        v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.rv = rv; v.ra = ra; v.c1 = c1; v.c2 = c2;
        v.e_ar = ar; v.e_lr = lr; v.e_rr = rr; v.e_b1 = b1; v.e_b2 = b2; v.e_bb = bb;
        v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[i] = m_busy[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_last_lsu  = 1'b1;
        exp_q.delete();
        m_hold_addr = '0;
        m_hold_data = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model,
    // check registered write-port outputs. use_tbl selects table expectations.
    task automatic run_cycle(input vec_t v, input bit use_tbl);
        bit         alu_g, lsu_g, old_busy[32];
        logic [4:0] ga;
        logic [127:0] gd;
        reset = v.rst; alu_wr_valid = v.av; alu_wr_addr = v.aa; alu_wr_data = v.ad;
        lsu_wr_valid = v.lv; lsu_wr_addr = v.la; lsu_wr_data = v.ld;
        reserve_valid = v.rv; reserve_addr = v.ra; check_addr_1 = v.c1; check_addr_2 = v.c2;
        #4;
        alu_g = !v.rst && v.av && (!v.lv || m_last_lsu);
        lsu_g = !v.rst && v.lv && (!v.av || !m_last_lsu);
        if (use_tbl) begin
            check("alu_wr_ready", alu_wr_ready, v.e_ar);
            check("lsu_wr_ready", lsu_wr_ready, v.e_lr);
            check("reserve_ready", reserve_ready, v.e_rr);
            check("busy_1", busy_1, v.e_b1);
            check("busy_2", busy_2, v.e_b2);
            check("busy_bits", busy_bits, v.e_bb);
        end else begin
            check("alu_wr_ready", alu_wr_ready, alu_g);
            check("lsu_wr_ready", lsu_wr_ready, lsu_g);
            check("reserve_ready", reserve_ready, !m_busy[v.ra]);
            check("busy_1", busy_1, m_busy[v.c1]);
            check("busy_2", busy_2, m_busy[v.c2]);
            check("busy_bits", busy_bits, model_busy_vec());
        end
        @(posedge clock);
        #1;
        cyc++;
        if (v.rst) begin
            model_reset();
        end else begin
            old_busy = m_busy;
            if (exp_q.size() > 0) begin
                m_busy[exp_q[0][132:128]] = 1'b0;
                void'(exp_q.pop_front());
            end
            if (v.rv && !old_busy[v.ra]) m_busy[v.ra] = 1'b1;
            if (alu_g || lsu_g) begin
                ga = alu_g ? v.aa : v.la;
                gd = alu_g ? v.ad : v.ld;
                exp_q.push_back({ga, gd});
                m_hold_addr = ga;
                m_hold_data = gd;
                m_last_lsu  = lsu_g;
            end
        end
        if (use_tbl) begin
            check("rf_write_enable", rf_write_enable, v.e_we);
            check("rf_write_addr", rf_write_addr, v.e_wa);
            check("rf_write_data", rf_write_data, v.e_wd);
        end else begin
            check("rf_write_enable", rf_write_enable, exp_q.size() > 0);
            check("rf_write_addr", rf_write_addr, m_hold_addr);
            check("rf_write_data", rf_write_data, m_hold_data);
        end
    endtask

    vec_t tbl[$];
    vec_t rv_vec;

    initial begin
        reset = 1'b1;
        alu_wr_valid = 0; alu_wr_addr = 0; alu_wr_data = 0;
        lsu_wr_valid = 0; lsu_wr_addr = 0; lsu_wr_data = 0;
        reserve_valid = 0; reserve_addr = 0; check_addr_1 = 0; check_addr_2 = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check("reset busy_bits", busy_bits, 32'h0);
        check("reset rf_write_enable", rf_write_enable, 1'b0);
        check("reset rf_write_addr", rf_write_addr, 5'd0);
        check("reset rf_write_data", rf_write_data, D0);

        //            rst av aa  ad  lv la  ld  rv ra  c1  c2   ar lr rr b1 b2 bb           we wa  wd
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 32'h0,     0, 0, D0));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 3, 3, 0,   0, 0, 1, 0, 0, 32'h0,     0, 0, D0));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 3, 3, 0,   0, 0, 0, 1, 0, 32'h8,     0, 0, D0));
        tbl.push_back(mk(0, 1, 3, D1, 0, 0, D0, 0, 3, 3, 0,   1, 0, 0, 1, 0, 32'h8,     1, 3, D1));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 3, 0,   0, 0, 1, 1, 0, 32'h8,     0, 3, D1));
        tbl.push_back(mk(0, 0, 0, D0, 1, 5, D2, 0, 0, 3, 0,   0, 1, 1, 0, 0, 32'h0,     1, 5, D2));
        tbl.push_back(mk(0, 1, 2, D3, 1, 5, D2, 0, 0, 5, 2,   1, 0, 1, 0, 0, 32'h0,     1, 2, D3));
        tbl.push_back(mk(0, 1, 2, D3, 1, 5, D2, 0, 0, 5, 2,   0, 1, 1, 0, 0, 32'h0,     1, 5, D2));
        tbl.push_back(mk(0, 1, 2, D3, 1, 5, D2, 0, 0, 5, 2,   1, 0, 1, 0, 0, 32'h0,     1, 2, D3));
        tbl.push_back(mk(0, 1, 2, D3, 1, 5, D2, 0, 0, 5, 2,   0, 1, 1, 0, 0, 32'h0,     1, 5, D2));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 5, 5, 2,   0, 0, 1, 0, 0, 32'h0,     0, 5, D2));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 5, 2,   0, 0, 1, 1, 0, 32'h20,    0, 5, D2));
        tbl.push_back(mk(0, 0, 0, D0, 1, 5, D4, 0, 0, 5, 2,   0, 1, 1, 1, 0, 32'h20,    1, 5, D4));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 5, 2,   0, 0, 1, 1, 0, 32'h20,    0, 5, D4));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 5, 2,   0, 0, 1, 0, 0, 32'h0,     0, 5, D4));
        tbl.push_back(mk(0, 1, 7, D1, 0, 0, D0, 0, 0, 7, 0,   1, 0, 1, 0, 0, 32'h0,     1, 7, D1));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 7, 7, 0,   0, 0, 1, 0, 0, 32'h0,     0, 7, D1));
        tbl.push_back(mk(0, 1, 4, D3, 0, 0, D0, 0, 0, 7, 4,   1, 0, 1, 1, 0, 32'h80,    1, 4, D3));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 9, 4, 9,   0, 0, 1, 0, 0, 32'h80,    0, 4, D3));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 4, 9,   0, 0, 1, 0, 1, 32'h280,   0, 4, D3));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 1, 1, 2,   0, 0, 1, 0, 0, 32'h280,   0, 4, D3));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 1, 2, 1, 2,   0, 0, 1, 1, 0, 32'h282,   0, 4, D3));
        tbl.push_back(mk(0, 1, 1, D1, 0, 0, D0, 0, 0, 1, 2,   1, 0, 1, 1, 1, 32'h286,   1, 1, D1));
        tbl.push_back(mk(1, 1, 2, D3, 1, 3, D2, 0, 0, 1, 2,   0, 0, 1, 1, 1, 32'h286,   0, 0, D0));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 1, 2,   0, 0, 1, 0, 0, 32'h0,     0, 0, D0));
        tbl.push_back(mk(0, 1, 8, D3, 1, 6, D2, 0, 0, 0, 0,   1, 0, 1, 0, 0, 32'h0,     1, 8, D3));
        tbl.push_back(mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 32'h0,     0, 8, D3));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // Random traffic over a narrow address range to force collisions.
        for (int n = 0; n < 800; n++) begin
            rv_vec = mk(0, 0, 0, D0, 0, 0, D0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, D0);
            rv_vec.rst = ($urandom_range(0, 79) == 0);
            rv_vec.av  = ($urandom_range(0, 2) != 0);
            rv_vec.aa  = 5'($urandom_range(0, 7));
            rv_vec.ad  = {$urandom, $urandom, $urandom, $urandom};
            rv_vec.lv  = ($urandom_range(0, 2) != 0);
            rv_vec.la  = 5'($urandom_range(0, 7));
            rv_vec.ld  = {$urandom, $urandom, $urandom, $urandom};
            rv_vec.rv  = ($urandom_range(0, 1) != 0);
            rv_vec.ra  = 5'($urandom_range(0, 9));
            rv_vec.c1  = 5'($urandom_range(0, 9));
            rv_vec.c2  = 5'($urandom_range(0, 31));
            run_cycle(rv_vec, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
